// File: rtl/swb_pkg.sv
// swb_pkg: FSM state type and count-width helper shared by serial_window_buffer.
package swb_pkg;
  typedef enum logic {FILL, FULL} state_t;
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/serial_window_buffer.sv
// serial_window_buffer: packs serial words into a DEPTH-word window handed off by valid/ready.
// Define SWB_SLIDE_EN to keep DEPTH-STRIDE words after each handoff (sliding window).
module serial_window_buffer import swb_pkg::*; #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 80,
  parameter int STRIDE = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DEPTH*WIDTH-1:0]   out_data,
  output logic [cnt_w(DEPTH)-1:0]  count
);
  localparam int CW = cnt_w(DEPTH);
  if (DEPTH < 2 || DEPTH > 256 || STRIDE < 1 || STRIDE >= DEPTH) begin : g_bad_cfg
    $error("serial_window_buffer: DEPTH or STRIDE out of range");
  end
  state_t r_state, w_state;
  logic [CW-1:0] r_count, w_count;
  logic [DEPTH-1:0][WIDTH-1:0] r_mem, w_mem;
  logic w_acc, w_hs;
  // in_ready is gated by rst directly so it drops the instant reset asserts
  assign in_ready  = !rst && r_state == FILL;
  assign out_valid = r_state == FULL;
  assign out_data  = out_valid ? r_mem : '0;
  assign count     = r_count;
  assign w_acc     = in_valid && in_ready && !flush;
  assign w_hs      = out_valid && out_ready && !flush;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= FILL;
      r_count <= '0;
    end else begin
      r_state <= w_state;
      r_count <= w_count;
    end
  always_comb begin
    w_state = r_state;
    w_count = r_count;
    if (flush) begin
      w_state = FILL;
      w_count = '0;
    end else if (w_acc) begin
      w_count = r_count + CW'(1);
      w_state = r_count == CW'(DEPTH - 1) ? FULL : FILL;
    end else if (w_hs) begin
      w_state = FILL;
`ifdef SWB_SLIDE_EN
      w_count = CW'(DEPTH - STRIDE);
`else
      w_count = '0;
`endif
    end
  end
  always_comb begin
    w_mem = r_mem;
    for (int k = 0; k < DEPTH; k++)
      if (w_acc && r_count == CW'(k)) w_mem[k] = in_data;
`ifdef SWB_SLIDE_EN
    if (w_hs)
      for (int k = 0; k < DEPTH - STRIDE; k++) w_mem[k] = r_mem[k + STRIDE];
`endif
  end
  // storage is deliberately not reset; count alone defines what is valid
  always_ff @(posedge clk)
    r_mem <= w_mem;
endmodule

// File: tb/tb_serial_window_buffer.sv
// tb_serial_window_buffer: vector table, corner sequences and randomized queue-model check.
module tb_serial_window_buffer;
  localparam int WIDTH = 8, DEPTH = 4, STRIDE = 1;
`ifdef SWB_SLIDE_EN
  localparam bit SLIDE = 1'b1;
`else
  localparam bit SLIDE = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic in_ready, out_valid;
  logic [DEPTH*WIDTH-1:0] out_data;
  logic [2:0] count;
  int pass_cnt = 0, total_cnt = 0;

  serial_window_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .STRIDE(STRIDE)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic step(input logic iv, input logic [7:0] d, input logic ordy, input logic fl);
    @(negedge clk);
    in_valid = iv; in_data = d; out_ready = ordy; flush = fl;
    @(posedge clk);
    #1;
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
  endtask

  typedef struct {
    logic        iv;
    logic [7:0]  d;
    logic        ordy;
    logic [2:0]  e_cnt;
    logic        e_vld;
    logic        e_rdy;
    logic [31:0] e_data;
  } vec_t;
  vec_t vec[11];

  logic [7:0] q[$];
  logic [31:0] exp_data;
  int acc_words, cyc;
  logic r_iv, r_or, r_fl;

  initial begin
    vec[0]  = '{1'b1, 8'h11, 1'b0, 3'd1, 1'b0, 1'b1, 32'h0};
    vec[1]  = '{1'b1, 8'h22, 1'b0, 3'd2, 1'b0, 1'b1, 32'h0};
    vec[2]  = '{1'b1, 8'h33, 1'b0, 3'd3, 1'b0, 1'b1, 32'h0};
    vec[3]  = '{1'b1, 8'h44, 1'b0, 3'd4, 1'b1, 1'b0, 32'h44332211};
    for (int i = 4; i < 9; i++)
      vec[i] = '{1'b1, 8'hAA, 1'b0, 3'd4, 1'b1, 1'b0, 32'h44332211};
    vec[9]  = '{1'b1, 8'hBB, 1'b1, SLIDE ? 3'd3 : 3'd0, 1'b0, 1'b1, 32'h0};
    vec[10] = SLIDE ? '{1'b1, 8'h55, 1'b0, 3'd4, 1'b1, 1'b0, 32'h55443322}
                    : '{1'b1, 8'h55, 1'b0, 3'd1, 1'b0, 1'b1, 32'h0};

    #2;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_out_data", out_data, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel_in_ready", in_ready, 1);

    foreach (vec[i]) begin
      step(vec[i].iv, vec[i].d, vec[i].ordy, 1'b0);
      chk($sformatf("vec%0d_count", i), count, vec[i].e_cnt);
      chk($sformatf("vec%0d_valid", i), out_valid, vec[i].e_vld);
      chk($sformatf("vec%0d_ready", i), in_ready, vec[i].e_rdy);
      chk($sformatf("vec%0d_data", i), out_data, vec[i].e_data);
    end

    // flush after two words, flush overrides a simultaneous accept
    do_reset();
    step(1'b1, 8'h01, 1'b0, 1'b0);
    step(1'b1, 8'h02, 1'b0, 1'b0);
    chk("fl_pre_count", count, 2);
    step(1'b1, 8'hFF, 1'b0, 1'b1);
    chk("fl_count", count, 0);
    chk("fl_valid", out_valid, 0);
    for (int i = 1; i <= 4; i++) step(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0);
    chk("fl_win_data", out_data, 32'hA4A3A2A1);
    chk("fl_win_count", count, 4);
    // flush overrides a simultaneous handshake in FULL
    step(1'b0, 8'h00, 1'b1, 1'b1);
    chk("flhs_count", count, 0);
    chk("flhs_valid", out_valid, 0);

    // asynchronous reset mid-fill
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 8'h70 + 8'(i), 1'b0, 1'b0);
    chk("ar_pre_count", count, 3);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_count", count, 0);
    chk("ar_valid", out_valid, 0);
    chk("ar_ready", in_ready, 0);
    chk("ar_data", out_data, 0);
    @(negedge clk);
    rst = 1'b0;

    // asynchronous reset while FULL
    for (int i = 0; i < 4; i++) step(1'b1, 8'h80 + 8'(i), 1'b0, 1'b0);
    chk("arf_pre_valid", out_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arf_valid", out_valid, 0);
    chk("arf_data", out_data, 0);
    chk("arf_count", count, 0);
    @(negedge clk);
    rst = 1'b0;

    // randomized traffic against a queue model
    q.delete();
    acc_words = 0;
    cyc = 0;
    while (acc_words < 1000 && cyc < 20000) begin
      @(negedge clk);
      r_iv = ($urandom_range(0, 9) < 6);
      r_or = ($urandom_range(0, 9) < 5);
      r_fl = ($urandom_range(0, 49) == 0);
      in_valid = r_iv; out_ready = r_or; flush = r_fl;
      in_data = 8'($urandom);
      #1;
      exp_data = '0;
      if (q.size() == DEPTH)
        foreach (q[i]) exp_data[i*8 +: 8] = q[i];
      chk("rand_count", count, q.size());
      chk("rand_valid", out_valid, q.size() == DEPTH);
      chk("rand_ready", in_ready, q.size() < DEPTH);
      chk("rand_data", out_data, exp_data);
      if (r_fl) q.delete();
      else if (r_iv && q.size() < DEPTH) begin
        q.push_back(in_data);
        acc_words++;
      end else if (r_or && q.size() == DEPTH) begin
        if (SLIDE) for (int i = 0; i < STRIDE; i++) void'(q.pop_front());
        else q.delete();
      end
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    chk("rand_words_done", acc_words >= 1000, 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
